// File: rtl/microseq_pkg.sv
// rtl/microseq_pkg.sv - shared types and defaults for the microprogram sequencer
//
// Purpose: next-address instruction encoding and default sizing constants.
// Optional feature macro used elsewhere in the bundle: MICROSEQ_STACK_ERR_EN.
package microseq_pkg;

    localparam int ADDR_W_DEF      = 12;
    localparam int STACK_DEPTH_DEF = 5;

    typedef enum logic [3:0] {
        JZ   = 4'd0,
        CJS  = 4'd1,
        JMAP = 4'd2,
        CJP  = 4'd3,
        PUSH = 4'd4,
        JSRP = 4'd5,
        CJV  = 4'd6,
        JRP  = 4'd7,
        RFCT = 4'd8,
        RPCT = 4'd9,
        CRTN = 4'd10,
        CJPP = 4'd11,
        LDCT = 4'd12,
        LOOP = 4'd13,
        CONT = 4'd14,
        TWB  = 4'd15
    } inst_e;

endpackage

// File: rtl/microseq_stack.sv
// rtl/microseq_stack.sv - LIFO subroutine/loop stack for the sequencer
//
// Purpose: push/pop/clear LIFO. A push while full overwrites the top slot and
// keeps SP; a pop while empty keeps SP at 0. tos_o reads 0 when empty.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   push_i, pop_i       stack operations (mutually exclusive)
//   clear_i             empty the stack (SP <= 0), entries keep their data
//   data_i              value to push
//   tos_o               top of stack, 0 when empty
//   full_n_o            low when STACK_DEPTH entries are held (registered)
//   err_o               (MICROSEQ_STACK_ERR_EN only) push-while-full or
//                       pop-while-empty pulse for the current cycle
import microseq_pkg::*;

module microseq_stack #(
    parameter int W     = ADDR_W_DEF,
    parameter int DEPTH = STACK_DEPTH_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] tos_o,
`ifdef MICROSEQ_STACK_ERR_EN
    output logic         err_o,
`endif
    output logic         full_n_o
);

    localparam int SP_W = $clog2(DEPTH + 1);

    logic [W-1:0]    stack_q [DEPTH];
    logic [SP_W-1:0] sp_q;
    logic            full_n_q;
    logic            empty;
    logic [SP_W-1:0] wr_idx;

    assign empty  = (sp_q == '0);
    // When full the top slot is rewritten in place instead of growing.
    assign wr_idx = full_n_q ? sp_q : SP_W'(DEPTH - 1);

    always_comb begin
        tos_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (SP_W'(i + 1) == sp_q) tos_o = stack_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q     <= '0;
            full_n_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else if (clear_i) begin
            sp_q     <= '0;
            full_n_q <= 1'b1;
        end else if (push_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (SP_W'(i) == wr_idx) stack_q[i] <= data_i;
            end
            if (full_n_q) begin
                sp_q     <= sp_q + 1'b1;
                full_n_q <= (sp_q + 1'b1) != SP_W'(DEPTH);
            end
        end else if (pop_i && !empty) begin
            sp_q     <= sp_q - 1'b1;
            full_n_q <= 1'b1;
        end
    end

    assign full_n_o = full_n_q;

`ifdef MICROSEQ_STACK_ERR_EN
    assign err_o = (push_i & ~full_n_q) | (pop_i & empty);
`endif

endmodule

// File: rtl/microseq_2910.sv
// rtl/microseq_2910.sv - Am2910-compatible microprogram sequencer top
//
// Purpose: decodes the next-address instruction, holds uPC and the loop
// counter R, and drives the next microaddress plus jump-source enables.
// Optional feature: define MICROSEQ_STACK_ERR_EN to add the sticky stack_err
// output (set on push-while-full / pop-while-empty, cleared by reset or JZ).
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   din            direct branch address / counter load value
//   inst           next-address instruction 0..15
//   cc_n, ccen_n   condition code and condition enable (active-low)
//   ci             incrementer carry, uPC <= yout + ci
//   rld_n          unconditional R load from din (active-low)
//   yout           next microaddress (combinational, 0 during reset)
//   full_n         low when the stack is full
//   pl_n, map_n, vect_n  jump-source enables decoded from inst
import microseq_pkg::*;

module microseq_2910 #(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] din,
    input  logic [3:0]        inst,
    input  logic              cc_n,
    input  logic              ccen_n,
    input  logic              ci,
    input  logic              rld_n,
    output logic [ADDR_W-1:0] yout,
    output logic              full_n,
    output logic              pl_n,
    output logic              map_n,
`ifdef MICROSEQ_STACK_ERR_EN
    output logic              stack_err,
`endif
    output logic              vect_n
);

    logic [ADDR_W-1:0] upc_q;
    logic [ADDR_W-1:0] r_q;
    logic [ADDR_W-1:0] r_d;
    logic [ADDR_W-1:0] yout_d;
    logic [ADDR_W-1:0] tos;
    logic              pass;
    logic              rz;
    logic              push;
    logic              pop;
    logic              clear;
    logic              r_ld;
    logic              r_dec;

    assign pass = ccen_n | ~cc_n;
    assign rz   = (r_q == '0);

    always_comb begin
        yout_d = upc_q;
        push   = 1'b0;
        pop    = 1'b0;
        clear  = 1'b0;
        r_ld   = 1'b0;
        r_dec  = 1'b0;
        case (inst_e'(inst))
            JZ:   begin yout_d = '0; clear = 1'b1; end
            CJS:  if (pass) begin yout_d = din; push = 1'b1; end
            JMAP: yout_d = din;
            CJP:  if (pass) yout_d = din;
            PUSH: begin push = 1'b1; r_ld = pass; end
            JSRP: begin push = 1'b1; yout_d = pass ? din : r_q; end
            CJV:  if (pass) yout_d = din;
            JRP:  yout_d = pass ? din : r_q;
            RFCT: if (!rz) begin yout_d = tos; r_dec = 1'b1; end
                  else pop = 1'b1;
            RPCT: if (!rz) begin yout_d = din; r_dec = 1'b1; end
            CRTN: if (pass) begin yout_d = tos; pop = 1'b1; end
            CJPP: if (pass) begin yout_d = din; pop = 1'b1; end
            LDCT: r_ld = 1'b1;
            LOOP: if (pass) pop = 1'b1;
                  else yout_d = tos;
            CONT: ;
            TWB:  if (pass) pop = 1'b1;
                  else if (!rz) begin yout_d = tos; r_dec = 1'b1; end
                  else begin yout_d = din; pop = 1'b1; end
            default: ;
        endcase
        if (reset) yout_d = '0;
    end

    // External rld_n load takes priority over anything the instruction asks.
    always_comb begin
        r_d = r_q;
        if (!rld_n || r_ld) r_d = din;
        else if (r_dec)     r_d = r_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            upc_q <= '0;
            r_q   <= '0;
        end else begin
            upc_q <= yout_d + {{(ADDR_W-1){1'b0}}, ci};
            r_q   <= r_d;
        end
    end

`ifdef MICROSEQ_STACK_ERR_EN
    logic stk_err_pulse;
    logic stack_err_q;

    always_ff @(posedge clock) begin
        if (reset || clear)    stack_err_q <= 1'b0;
        else if (stk_err_pulse) stack_err_q <= 1'b1;
    end

    assign stack_err = stack_err_q;
`endif

    microseq_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock    (clock),
        .reset    (reset),
        .push_i   (push),
        .pop_i    (pop),
        .clear_i  (clear),
        .data_i   (upc_q),
        .tos_o    (tos),
`ifdef MICROSEQ_STACK_ERR_EN
        .err_o    (stk_err_pulse),
`endif
        .full_n_o (full_n)
    );

    assign yout   = yout_d;
    assign pl_n   = (inst == JMAP) || (inst == CJV);
    assign map_n  = (inst != JMAP);
    assign vect_n = (inst != CJV);

endmodule
